// File: rtl/mem_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_load_store_unit                                          |
// | Description : Load/store sequencer between the execute stage and data      |
// |               memory. Accepts one request, issues a word-aligned bus       |
// |               transaction with byte strobes, waits for read data and       |
// |               holds the response until the consumer takes it.            |
// | Options     : MISALIGN_TRAP_EN - when defined, misaligned HALF/WORD        |
// |               requests are answered with an error and no bus access;       |
// |               otherwise the address is forced aligned.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package mem_lsu_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;
endpackage

module mem_load_store_unit
    import mem_lsu_pkg::*;
#(
    parameter int L = 128,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [$clog2(L)-1:0] req_addr,
    input  logic                 req_wr,
    input  mem_access_t          req_access,
    input  logic                 req_unsign,
    input  logic [W-1:0]         req_wdata,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [$clog2(L)-1:0] bus_addr,
    output logic                 bus_wr,
    output logic [W-1:0]         bus_wdata,
    output logic [W/8-1:0]       bus_wstrb,
    input  logic                 bus_rvalid,
    input  logic [W-1:0]         bus_rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_addr_lo,
    output mem_access_t          rsp_access,
    output logic                 rsp_unsign,
    output logic [W-1:0]         rsp_rdata,
    output logic                 rsp_err
);

    localparam int c_AW = $clog2(L);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE  = 2'd1;
    localparam logic [1:0] c_ST_WAIT_R = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    // Lane logic below is written for a 32-bit word only.
    generate
        if (W != 32) begin : g_width_check
            $fatal(1, "mem_load_store_unit: W=%0d unsupported, only 32", W);
        end
    endgenerate

    logic [1:0]     r_state;
    logic [c_AW-1:0] r_addr;
    logic           r_wr;
    logic [W-1:0]   r_wdata;
    logic [W/8-1:0] r_wstrb;
    logic [1:0]     r_addr_lo;
    mem_access_t    r_access;
    logic           r_unsign;
    logic [W-1:0]   r_rdata;
    logic           r_err;

    logic [1:0]     w_lo;
    logic [1:0]     w_eff_lo;
    logic           w_bad_enc;
    logic           w_misalign;
    logic           w_err;
    logic [W/8-1:0] w_wstrb;
    logic [W-1:0]   w_wdata;

    // Request decode: alignment, effective low address bits, lane strobes/data.
    always_comb begin
        w_lo       = req_addr[1:0];
        w_eff_lo   = w_lo;
        w_bad_enc  = 1'b0;
        w_misalign = 1'b0;
        w_wstrb    = '0;
        w_wdata    = req_wdata;
        case (req_access)
            MEM_ACCESS_BYTE: begin
                w_wstrb = 4'b0001 << w_lo;
                w_wdata = {4{req_wdata[7:0]}};
            end
            MEM_ACCESS_HALF: begin
                w_misalign = w_lo[0];
                w_eff_lo   = w_misalign ? {w_lo[1], 1'b0} : w_lo;
                w_wstrb    = w_eff_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{req_wdata[15:0]}};
            end
            MEM_ACCESS_WORD: begin
                w_misalign = |w_lo;
                w_eff_lo   = w_misalign ? 2'b00 : w_lo;
                w_wstrb    = 4'b1111;
            end
            default: w_bad_enc = 1'b1;
        endcase
`ifdef MISALIGN_TRAP_EN
        w_err = w_bad_enc | w_misalign;
`else
        w_err = w_bad_enc;
`endif
    end

    // Sequencer FSM and request/response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_addr_lo <= 2'b00;
            r_access  <= MEM_ACCESS_BYTE;
            r_unsign  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        // Errors report the caller's address; otherwise the forced one.
                        r_addr_lo <= w_err ? w_lo : w_eff_lo;
                        r_addr    <= {req_addr[c_AW-1:2], 2'b00};
                        r_wr      <= req_wr;
                        r_wdata   <= w_wdata;
                        r_wstrb   <= (req_wr && !w_err) ? w_wstrb : '0;
                        r_access  <= req_access;
                        r_unsign  <= req_unsign;
                        r_rdata   <= '0;
                        r_err     <= w_err;
                        r_state   <= w_err ? c_ST_RESP : c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (bus_ready) begin
                        r_state <= r_wr ? c_ST_RESP : c_ST_WAIT_R;
                    end
                end
                c_ST_WAIT_R: begin
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                        r_state <= c_ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs are forced to zero for as long as reset is held.
    assign req_ready   = !rst && (r_state == c_ST_IDLE);
    assign bus_valid   = !rst && (r_state == c_ST_ISSUE);
    assign bus_addr    = rst ? '0 : r_addr;
    assign bus_wr      = !rst && r_wr;
    assign bus_wdata   = rst ? '0 : r_wdata;
    assign bus_wstrb   = rst ? '0 : r_wstrb;
    assign rsp_valid   = !rst && (r_state == c_ST_RESP);
    assign rsp_addr_lo = rst ? 2'b00 : r_addr_lo;
    assign rsp_access  = rst ? MEM_ACCESS_BYTE : r_access;
    assign rsp_unsign  = !rst && r_unsign;
    assign rsp_rdata   = rst ? '0 : r_rdata;
    assign rsp_err     = !rst && r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_load_store_unit                                       |
// | Description : Self-checking bench for mem_load_store_unit: directed        |
// |               scenarios followed by random requests against a byte-array   |
// |               memory model and an arithmetic lane/alignment model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_load_store_unit;
    import mem_lsu_pkg::*;

`ifdef MISALIGN_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic        req_wr = 1'b0;
    mem_access_t req_access = MEM_ACCESS_BYTE;
    logic        req_unsign = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [6:0]  bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_addr_lo;
    mem_access_t rsp_access;
    logic        rsp_unsign;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] mem [128];

    mem_load_store_unit #(.L(128), .W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_access(req_access), .req_unsign(req_unsign),
        .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr_lo(rsp_addr_lo),
        .rsp_access(rsp_access), .rsp_unsign(rsp_unsign), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with chosen bus/read/response stall lengths.
    task automatic do_txn(input logic [6:0] addr, input logic wr, input logic [1:0] acc,
                          input logic [31:0] wd, input logic uns,
                          input int bdly, input int rdly, input int pdly);
        int size, eff, base;
        bit ok, mis, err;
        logic [3:0]  estrb;
        logic [31:0] ewd, erd;
        ok    = (acc != 2'd3);
        size  = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
        mis   = ok && ((int'(addr) % size) != 0);
        err   = !ok || (c_TRAP && mis);
        eff   = err ? int'(addr) : int'(addr) - (int'(addr) % size);
        base  = eff - (eff % 4);
        estrb = wr ? 4'(((1 << size) - 1) << (eff % 4)) : 4'h0;
        for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wd[8*(k % size) +: 8];
        erd = '0;

        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wr     = wr;
        req_access = mem_access_t'(acc);
        req_wdata  = wd;
        req_unsign = uns;
        tick();
        req_valid  = 1'b0;

        if (err) begin
            chk("err_no_bus", {31'b0, bus_valid}, 32'd0);
        end else begin
            for (int c = 0; c <= bdly; c++) begin
                chk("bus_valid", {31'b0, bus_valid}, 32'd1);
                chk("bus_addr", {25'b0, bus_addr}, 32'(base));
                chk("bus_wr", {31'b0, bus_wr}, {31'b0, wr});
                chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, estrb});
                if (wr) chk("bus_wdata", bus_wdata, ewd);
                chk("rsp_early", {31'b0, rsp_valid}, 32'd0);
                bus_ready = (c == bdly);
                tick();
            end
            bus_ready = 1'b0;
            if (wr) begin
                for (int k = 0; k < 4; k++)
                    if (estrb[k]) mem[base + k] = ewd[8*k +: 8];
            end else begin
                erd = {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
                for (int c = 0; c <= rdly; c++) begin
                    chk("wait_bus_idle", {31'b0, bus_valid}, 32'd0);
                    chk("wait_rsp_low", {31'b0, rsp_valid}, 32'd0);
                    bus_rvalid = (c == rdly);
                    bus_rdata  = (c == rdly) ? erd : $urandom;
                    tick();
                end
                bus_rvalid = 1'b0;
                bus_rdata  = $urandom;
            end
        end

        for (int c = 0; c <= pdly; c++) begin
            chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
            chk("rsp_rdata", rsp_rdata, erd);
            chk("rsp_addr_lo", {30'b0, rsp_addr_lo}, 32'(eff % 4));
            chk("rsp_access", {30'b0, rsp_access}, {30'b0, acc});
            chk("rsp_unsign", {31'b0, rsp_unsign}, {31'b0, uns});
            chk("req_ready_resp", {31'b0, req_ready}, 32'd0);
            rsp_ready = (c == pdly);
            if (pdly > 0) begin
                req_valid  = 1'b1;
                req_addr   = 7'($urandom);
                req_wr     = 1'($urandom);
                req_access = mem_access_t'(2'($urandom));
            end
            tick();
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_dropped", {31'b0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

        // Reset state: every output low while rst is held.
        tick();
        tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
        chk("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        #1;

        // Load WORD at 0x10 returning 0xDEADBEEF at minimum latency.
        {mem[19], mem[18], mem[17], mem[16]} = 32'hDEADBEEF;
        do_txn(7'h10, 1'b0, 2'd2, 32'h0, 1'b0, 0, 0, 0);
        // Store BYTE 0xA5 at 0x23.
        do_txn(7'h23, 1'b1, 2'd0, 32'h000000A5, 1'b0, 0, 0, 0);
        // Store HALF 0x1234 at 0x06 with bus_ready low for 3 cycles.
        do_txn(7'h06, 1'b1, 2'd1, 32'h00001234, 1'b1, 3, 0, 0);
        // Misaligned HALF load at 0x05.
        do_txn(7'h05, 1'b0, 2'd1, 32'h0, 1'b1, 0, 1, 0);
        // Invalid access encoding.
        do_txn(7'h08, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        // Misaligned WORD store.
        do_txn(7'h4B, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0, 0, 0, 0);
        // Response held 5 cycles with a competing request pending.
        do_txn(7'h30, 1'b0, 2'd0, 32'h0, 1'b1, 1, 2, 5);

        // Reset in WAIT_R: a late read beat must not produce a response.
        req_valid  = 1'b1;
        req_addr   = 7'h10;
        req_wr     = 1'b0;
        req_access = MEM_ACCESS_WORD;
        tick();
        req_valid = 1'b0;
        chk("rw_bus_valid", {31'b0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rw_rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rw_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rw_req_ready_after", {31'b0, req_ready}, 32'd1);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEADBEEF;
        tick();
        bus_rvalid = 1'b0;
        chk("rw_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("rw_still_idle", {31'b0, req_ready}, 32'd1);
        tick();
        chk("rw_no_rsp2", {31'b0, rsp_valid}, 32'd0);

        // Random requests against the memory model.
        for (int i = 0; i < 40; i++) begin
            do_txn(7'($urandom_range(0, 127)), 1'($urandom), 2'($urandom_range(0, 3)),
                   $urandom, 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
